// File: rtl/v_mem_resp_pkg.sv
// ----------------------------------------------------------------------------
// v_mem_resp_pkg
// Shared constants for the vector data-memory responder.
//   - FSM state encodings (VMEM_ST_IDLE .. VMEM_ST_RESP)
//   - element width (one SRAM word per vector element)
//   - beat-counter width (eight beats per whole-register transfer)
// ----------------------------------------------------------------------------
package v_mem_resp_pkg;

    localparam int ELEM_W = 32;
    localparam int BEAT_W = 3;

    typedef logic [2:0] vmem_state_t;

    localparam vmem_state_t VMEM_ST_IDLE  = 3'd0;
    localparam vmem_state_t VMEM_ST_WR    = 3'd1;
    localparam vmem_state_t VMEM_ST_RD    = 3'd2;
    localparam vmem_state_t VMEM_ST_DRAIN = 3'd3;
    localparam vmem_state_t VMEM_ST_RESP  = 3'd4;

endpackage

// File: rtl/v_mem_resp_lane_buf.sv
// ----------------------------------------------------------------------------
// v_mem_lane_buf
// Element buffer that assembles a vector load result one word at a time and
// presents it as one flat vector.
// Ports:
//   i_clk, i_rst_n  clock / asynchronous active-low reset
//   i_clr           zero every element (takes priority over i_we)
//   i_we, i_idx     write i_wdata into element i_idx
//   i_wdata         element write data
//   o_flat          all elements, element i at bits [32i+31:32i]
// ----------------------------------------------------------------------------
module v_mem_lane_buf
    import v_mem_resp_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clr,
    input  logic                      i_we,
    input  logic [BEAT_W-1:0]         i_idx,
    input  logic [ELEM_W-1:0]         i_wdata,
    output logic [LANES*ELEM_W-1:0]   o_flat
);

    logic [ELEM_W-1:0] r_elem [LANES];

    // Element storage; a clear on request accept guarantees stores and
    // aborted transfers never expose stale load data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_elem[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < LANES; i++) begin
                r_elem[i] <= '0;
            end
        end else if (i_we) begin
            r_elem[i_idx] <= i_wdata;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_flat
        assign o_flat[g*ELEM_W +: ELEM_W] = r_elem[g];
    end

endmodule

// File: rtl/v_mem_resp.sv
// ----------------------------------------------------------------------------
// v_mem_resp
// Vector data-memory responder. Serialises each whole-register vector load or
// store into eight single-word beats on a single-port word SRAM and returns
// the assembled load vector to the vector write-back path.
// Optional feature macro: VMEM_ALIGN_CHK_EN
//   defined   - requests whose byte address is not word aligned are rejected
//               without touching the SRAM and answered with resp_err_o=1
//   undefined - the low two address bits are ignored, resp_err_o is tied 0
// Ports:
//   clk, rst           clock / asynchronous active-low reset
//   req_valid_i/ready_o, req_wen_i, req_addr_i, req_wdata_i   request side
//   resp_valid_o/ready_i, resp_rdata_o, resp_err_o            response side
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i  SRAM side
//   (mem_rdata_i is valid the cycle after a read strobe)
// ----------------------------------------------------------------------------
module v_mem_resp
    import v_mem_resp_pkg::*;
#(
    parameter int VMEM_DW = 256,
    parameter int VMEM_AW = 32,
    parameter int VLMAX   = 8,
    parameter int MEM_AW  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_wen_i,
    input  logic [VMEM_AW-1:0]  req_addr_i,
    input  logic [VMEM_DW-1:0]  req_wdata_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [VMEM_DW-1:0]  resp_rdata_o,
    output logic                resp_err_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [MEM_AW-1:0]   mem_addr_o,
    output logic [ELEM_W-1:0]   mem_wdata_o,
    input  logic [ELEM_W-1:0]   mem_rdata_i
);

    vmem_state_t         r_state;
    logic [MEM_AW-1:0]   r_base;
    logic [BEAT_W-1:0]   r_beat;
    logic [VMEM_DW-1:0]  r_wdata;

    logic                w_accept;
    logic                w_last_beat;
    logic                w_misaligned;
    logic                w_buf_we;
    logic [BEAT_W-1:0]   w_buf_idx;
    logic                w_unused;

    assign w_accept    = (r_state == VMEM_ST_IDLE) && req_valid_i;
    assign w_last_beat = (r_beat == BEAT_W'(VLMAX - 1));

    // Address bits above the SRAM range are dropped (modulo addressing).
    assign w_unused = ^{req_addr_i[VMEM_AW-1:MEM_AW+2], req_addr_i[1:0]};

`ifdef VMEM_ALIGN_CHK_EN
    logic r_err;

    assign w_misaligned = |req_addr_i[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misaligned;
        end
    end

    assign resp_err_o = r_err;
`else
    assign w_misaligned = 1'b0;
    assign resp_err_o   = 1'b0;
`endif

    // Transfer sequencer. The beat counter stays on the last beat when
    // leaving WR/RD; DRAIN addresses the final element explicitly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= VMEM_ST_IDLE;
            r_base  <= '0;
            r_beat  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                VMEM_ST_IDLE: begin
                    if (req_valid_i) begin
                        r_base  <= req_addr_i[MEM_AW+1:2];
                        r_wdata <= req_wdata_i;
                        r_beat  <= '0;
                        if (w_misaligned) begin
                            r_state <= VMEM_ST_RESP;
                        end else if (req_wen_i) begin
                            r_state <= VMEM_ST_WR;
                        end else begin
                            r_state <= VMEM_ST_RD;
                        end
                    end
                end
                VMEM_ST_WR: begin
                    if (w_last_beat) begin
                        r_state <= VMEM_ST_RESP;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                VMEM_ST_RD: begin
                    if (w_last_beat) begin
                        r_state <= VMEM_ST_DRAIN;
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                VMEM_ST_DRAIN: begin
                    r_state <= VMEM_ST_RESP;
                end
                VMEM_ST_RESP: begin
                    if (resp_ready_i) begin
                        r_state <= VMEM_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= VMEM_ST_IDLE;
                end
            endcase
        end
    end

    // Read data lags the strobe by one cycle, so beat b lands in element b-1
    // and the last element is picked up in DRAIN.
    assign w_buf_we  = ((r_state == VMEM_ST_RD) && (r_beat != '0)) ||
                       (r_state == VMEM_ST_DRAIN);
    assign w_buf_idx = (r_state == VMEM_ST_DRAIN) ? BEAT_W'(VLMAX - 1)
                                                  : r_beat - BEAT_W'(1);

    v_mem_lane_buf #(
        .LANES   (VLMAX)
    ) u_lane_buf (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_accept),
        .i_we    (w_buf_we),
        .i_idx   (w_buf_idx),
        .i_wdata (mem_rdata_i),
        .o_flat  (resp_rdata_o)
    );

    assign req_ready_o  = (r_state == VMEM_ST_IDLE);
    assign resp_valid_o = (r_state == VMEM_ST_RESP);
    assign mem_en_o     = (r_state == VMEM_ST_WR) || (r_state == VMEM_ST_RD);
    assign mem_we_o     = (r_state == VMEM_ST_WR);

    // Address and write data are forced to zero outside an access so the
    // SRAM pins stay quiet between transfers; base+beat wraps naturally.
    assign mem_addr_o  = mem_en_o ? (r_base + MEM_AW'(r_beat)) : '0;
    assign mem_wdata_o = mem_we_o ? r_wdata[ELEM_W*int'(r_beat) +: ELEM_W] : '0;

endmodule

// File: tb/tb_v_mem_resp.sv
// ----------------------------------------------------------------------------
// tb_v_mem_resp
// Directed bench for v_mem_resp with a transaction-timeline reference model
// and a word SRAM model. Build with +define+VMEM_ALIGN_CHK_EN to exercise the
// alignment-check configuration.
// ----------------------------------------------------------------------------
module tb_v_mem_resp;

`ifdef VMEM_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_wen_i;
    logic [31:0]   req_addr_i;
    logic [255:0]  req_wdata_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [255:0]  resp_rdata_o;
    logic          resp_err_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [15:0]   mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;
    bit started = 1'b0;

    v_mem_resp dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_wen_i    (req_wen_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Unwritten words read back as a recognisable address-tagged pattern.
    function automatic logic [31:0] fillWord(input logic [15:0] a);
        return {16'hA5A5, a};
    endfunction

    // SRAM model driven by the DUT.
    logic [31:0] sram [65536];
    bit          sramWritten [65536];

    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                sram[mem_addr_o]        <= mem_wdata_o;
                sramWritten[mem_addr_o] <= 1'b1;
            end else begin
                mem_rdata_i <= sramWritten[mem_addr_o] ? sram[mem_addr_o] : fillWord(mem_addr_o);
            end
        end
    end

    // Reference model: a transaction timeline. mCycle counts cycles since the
    // accepting edge; stores write on cycles 1..8 and respond from 9, loads
    // read on cycles 1..8 and respond from 10, rejected requests respond at 1.
    bit            mBusy = 1'b0;
    bit            mWen;
    bit            mErr;
    int            mCycle = 0;
    logic [15:0]   mBase;
    logic [255:0]  mWdata;
    logic [31:0]   refMem [65536];
    bit            refWritten [65536];

    logic          expIdle, expRespValid, expEn, expWe;
    logic [15:0]   expAddr;
    logic [31:0]   expWdata;
    int            beatIdx;

    function automatic logic [31:0] refWord(input logic [15:0] a);
        return refWritten[a] ? refMem[a] : fillWord(a);
    endfunction

    always_comb begin
        beatIdx      = (mCycle >= 1 && mCycle <= 8) ? mCycle - 1 : 0;
        expIdle      = !mBusy;
        expRespValid = mBusy && (mErr || (mWen ? (mCycle >= 9) : (mCycle >= 10)));
        expEn        = mBusy && !mErr && (mCycle >= 1) && (mCycle <= 8);
        expWe        = expEn && mWen;
        expAddr      = mBase + 16'(beatIdx);
        expWdata     = mWdata[32*beatIdx +: 32];
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mBusy  <= 1'b0;
            mCycle <= 0;
        end else if (!mBusy) begin
            if (req_valid_i) begin
                mBusy  <= 1'b1;
                mCycle <= 1;
                mWen   <= req_wen_i;
                mErr   <= ALIGN && (req_addr_i[1:0] != 2'b00);
                mBase  <= req_addr_i[17:2];
                mWdata <= req_wdata_i;
            end
        end else begin
            if (expWe) begin
                refMem[expAddr]     <= expWdata;
                refWritten[expAddr] <= 1'b1;
            end
            if (expRespValid && resp_ready_i) begin
                mBusy <= 1'b0;
            end else begin
                mCycle <= mCycle + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle out of reset, DUT against the model.
    always @(negedge clk) begin
        if (started && rst) begin
            logic [255:0] expRdata;
            expRdata = '0;
            checkOutput("m_req_ready", req_ready_o, expIdle);
            checkOutput("m_resp_valid", resp_valid_o, expRespValid);
            checkOutput("m_mem_en", mem_en_o, expEn);
            checkOutput("m_mem_we", mem_we_o, expWe);
            if (expEn) checkOutput("m_mem_addr", mem_addr_o, expAddr);
            if (expWe) checkOutput("m_mem_wdata", mem_wdata_o, expWdata);
            if (expRespValid) begin
                if (!mWen && !mErr) begin
                    for (int i = 0; i < 8; i++) expRdata[32*i +: 32] = refWord(mBase + 16'(i));
                end
                checkOutput("m_resp_rdata", resp_rdata_o, expRdata);
                checkOutput("m_resp_err", resp_err_o, mErr);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) nextCycle();
    endtask

    // Presents one request for exactly one edge; returns in cycle 1.
    task automatic applyStimulus(input bit wen, input logic [31:0] addr, input logic [255:0] wdata);
        req_valid_i = 1'b1;
        req_wen_i   = wen;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(posedge clk);
        #1;
        cyc         = 1;
        req_valid_i = 1'b0;
    endtask

    // Bounded wait for the response, then one edge for the handshake.
    task automatic finishTxn();
        int n = 0;
        resp_ready_i = 1'b1;
        while (!resp_valid_o && n < 40) begin
            nextCycle();
            n++;
        end
        if (n == 40) checkOutput("resp_timeout", 1'b0, 1'b1);
        nextCycle();
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_req_ready"}, req_ready_o, 1'b1);
        checkOutput({pfx, "_resp_valid"}, resp_valid_o, 1'b0);
        checkOutput({pfx, "_resp_err"}, resp_err_o, 1'b0);
        checkOutput({pfx, "_resp_rdata"}, resp_rdata_o, '0);
        checkOutput({pfx, "_mem_en"}, mem_en_o, 1'b0);
        checkOutput({pfx, "_mem_we"}, mem_we_o, 1'b0);
        checkOutput({pfx, "_mem_addr"}, mem_addr_o, 16'h0000);
        checkOutput({pfx, "_mem_wdata"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        logic [255:0] wd1, wd3, wd4, wd5, expLoad;
        logic [15:0]  wrapAddr [8];

        wrapAddr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
                     16'h0002, 16'h0003, 16'h0004, 16'h0005};
        expLoad  = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
        for (int i = 0; i < 8; i++) begin
            wd1[32*i +: 32] = 32'h11111111 * (i + 1);
            wd3[32*i +: 32] = 32'h3000_0000 + i;
            wd4[32*i +: 32] = 32'hC0DE_0000 + i;
            wd5[32*i +: 32] = 32'hDEAD_0000 + i;
        end

        req_valid_i  = 1'b0;
        req_wen_i    = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        resp_ready_i = 1'b1;

        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst     = 1'b1;
        started = 1'b1;
        nextCycle();

        $display("[TB] store 0x1000");
        applyStimulus(1'b1, 32'h0000_1000, wd1);
        checkOutput("st_c1_addr", mem_addr_o, 16'h0400);
        checkOutput("st_c1_enwe", {mem_en_o, mem_we_o}, 2'b11);
        checkOutput("st_c1_wdata", mem_wdata_o, 32'h11111111);
        runTo(8);
        checkOutput("st_c8_addr", mem_addr_o, 16'h0407);
        checkOutput("st_c8_wdata", mem_wdata_o, 32'h88888888);
        checkOutput("st_c8_valid", resp_valid_o, 1'b0);
        nextCycle();
        checkOutput("st_c9_valid", resp_valid_o, 1'b1);
        checkOutput("st_c9_rdata", resp_rdata_o, '0);
        nextCycle();
        checkOutput("st_after_ready", req_ready_o, 1'b1);

        $display("[TB] load 0x1000");
        applyStimulus(1'b0, 32'h0000_1000, '0);
        checkOutput("ld_c1_enwe", {mem_en_o, mem_we_o}, 2'b10);
        checkOutput("ld_c1_addr", mem_addr_o, 16'h0400);
        runTo(9);
        checkOutput("ld_c9_valid", resp_valid_o, 1'b0);
        checkOutput("ld_c9_en", mem_en_o, 1'b0);
        nextCycle();
        checkOutput("ld_c10_valid", resp_valid_o, 1'b1);
        checkOutput("ld_c10_rdata", resp_rdata_o, expLoad);
        nextCycle();

        $display("[TB] load wrap 0x3FFF8");
        applyStimulus(1'b0, 32'h0003_FFF8, '0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("wrap_addr%0d", k), mem_addr_o, wrapAddr[k]);
            nextCycle();
        end
        nextCycle();
        checkOutput("wrap_elem0", resp_rdata_o[31:0], 32'hA5A5FFFE);
        checkOutput("wrap_elem7", resp_rdata_o[255:224], 32'hA5A50005);
        nextCycle();

        $display("[TB] load with backpressure");
        resp_ready_i = 1'b0;
        applyStimulus(1'b0, 32'h0000_1000, '0);
        runTo(10);
        checkOutput("bp_c10_valid", resp_valid_o, 1'b1);
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            checkOutput("bp_hold_valid", resp_valid_o, 1'b1);
            checkOutput("bp_hold_ready", req_ready_o, 1'b0);
            checkOutput("bp_hold_rdata", resp_rdata_o, expLoad);
        end
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_wen_i    = 1'b1;
        req_addr_i   = 32'h0000_3000;
        req_wdata_i  = wd3;
        nextCycle();
        checkOutput("bp_next_ready", req_ready_o, 1'b1);
        checkOutput("bp_next_valid", resp_valid_o, 1'b0);
        nextCycle();
        req_valid_i = 1'b0;
        checkOutput("bp_next_en", mem_en_o, 1'b1);
        checkOutput("bp_next_addr", mem_addr_o, 16'h0C00);
        finishTxn();

        $display("[TB] reset during store beat 3");
        applyStimulus(1'b1, 32'h0000_2000, wd4);
        runTo(4);
        checkOutput("rs_c4_addr", mem_addr_o, 16'h0803);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkReset("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 32'h0000_2000, '0);
        runTo(10);
        checkOutput("rs_ld_valid", resp_valid_o, 1'b1);
        checkOutput("rs_ld_elem0", resp_rdata_o[31:0], 32'hC0DE0000);
        checkOutput("rs_ld_elem2", resp_rdata_o[95:64], 32'hC0DE0002);
        checkOutput("rs_ld_elem3", resp_rdata_o[127:96], 32'hA5A50803);
        nextCycle();

        $display("[TB] store to 0x1002");
        applyStimulus(1'b1, 32'h0000_1002, wd5);
        if (ALIGN) begin
            checkOutput("mis_c1_valid", resp_valid_o, 1'b1);
            checkOutput("mis_c1_err", resp_err_o, 1'b1);
            checkOutput("mis_c1_en", mem_en_o, 1'b0);
            checkOutput("mis_c1_rdata", resp_rdata_o, '0);
        end else begin
            checkOutput("mis_c1_en", mem_en_o, 1'b1);
            checkOutput("mis_c1_addr", mem_addr_o, 16'h0400);
            checkOutput("mis_c1_wdata", mem_wdata_o, 32'hDEAD0000);
        end
        finishTxn();
        applyStimulus(1'b0, 32'h0000_1000, '0);
        runTo(10);
        checkOutput("mis_ld_elem0", resp_rdata_o[31:0], ALIGN ? 32'h11111111 : 32'hDEAD0000);
        checkOutput("mis_ld_err", resp_err_o, 1'b0);
        nextCycle();
        nextCycle();

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
